// File: rtl/conv_layer_pkg.sv
// Shared conv-layer definitions: geometry, occupancy state encoding and logb2.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package conv_layer_pkg;

    localparam int BUFFER_COL  = 8;
    localparam int KERNEL_SIZE = 3;
    localparam int OUT_COL     = BUFFER_COL - KERNEL_SIZE + 1;
    localparam int MAP_ROWS    = 6;

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_TWO   = 2'd2;

    // Bits needed to index 0..value-1, never less than one.
    function automatic int logb2(input int value);
        int w;
        w = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            w++;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/conv_layer_row_mux.sv
// Combinational element select from a packed row; column 0 sits in the top slice.
module conv_layer_row_mux
    import conv_layer_pkg::*;
#(
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int OUT_COL    = conv_layer_pkg::OUT_COL
) (
    input  logic [OUT_COL*DATA_WIDTH-1:0] row_i,
    input  logic [logb2(OUT_COL)-1:0]     col_i,
    output logic [DATA_WIDTH-1:0]         elem_o
);

    localparam int COL_W = logb2(OUT_COL);

    // Out-of-range column indices select zero instead of reading past the row.
    always_comb begin
        elem_o = '0;
        for (int c = 0; c < OUT_COL; c++) begin
            if (col_i == COL_W'(c)) begin
                elem_o = row_i[(OUT_COL-1-c)*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

endmodule

// File: rtl/conv_layer_output_buffer.sv
// Ping-pong output row buffer: takes whole rows from the PE array and streams
// them one element per cycle with column/row tags and end markers.
module conv_layer_output_buffer
    import conv_layer_pkg::*;
#(
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int OUT_COL    = conv_layer_pkg::OUT_COL,
    parameter int MAP_ROWS   = conv_layer_pkg::MAP_ROWS
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear,
    input  logic [OUT_COL*DATA_WIDTH-1:0] row_in,
    input  logic                          row_valid,
    output logic                          row_ready,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [logb2(OUT_COL)-1:0]     out_col,
    output logic [logb2(MAP_ROWS)-1:0]    out_row,
    output logic                          out_eol,
    output logic                          out_last,
    output logic                          map_done
);

    localparam int COL_W = logb2(OUT_COL);
    localparam int ROW_W = logb2(MAP_ROWS);

    logic [OUT_COL*DATA_WIDTH-1:0] bank_q [2];
    logic [1:0]       state_q, state_d;
    logic             wr_ptr_q, rd_ptr_q;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             map_done_q;
    logic             wr_en, rd_fire, retire, col_end, row_end;

    assign row_ready = (state_q != S_TWO);
    assign out_valid = (state_q != S_EMPTY);
    assign col_end   = (col_q == COL_W'(OUT_COL - 1));
    assign row_end   = (row_q == ROW_W'(MAP_ROWS - 1));
    assign out_eol   = out_valid && col_end;
    assign out_last  = out_eol && row_end;
    assign out_col   = col_q;
    assign out_row   = row_q;
    assign map_done  = map_done_q;

    assign wr_en   = row_valid && row_ready;
    assign rd_fire = out_valid && out_ready;
    assign retire  = rd_fire && col_end;

    conv_layer_row_mux #(
        .DATA_WIDTH (DATA_WIDTH),
        .OUT_COL    (OUT_COL)
    ) u_row_mux (
        .row_i  (bank_q[rd_ptr_q]),
        .col_i  (col_q),
        .elem_o (out_data)
    );

    // Occupancy only moves when exactly one of write/retire happens.
    always_comb begin
        state_d = state_q;
        case ({wr_en, retire})
            2'b10:   state_d = (state_q == S_EMPTY) ? S_ONE : S_TWO;
            2'b01:   state_d = (state_q == S_TWO) ? S_ONE : S_EMPTY;
            default: state_d = state_q;
        endcase

        col_d = col_q;
        row_d = row_q;
        if (retire) begin
            col_d = '0;
            row_d = row_end ? '0 : row_q + ROW_W'(1);
        end else if (rd_fire) begin
            col_d = col_q + COL_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_EMPTY;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            col_q      <= '0;
            row_q      <= '0;
            map_done_q <= 1'b0;
        end else if (clear) begin
            state_q    <= S_EMPTY;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            col_q      <= '0;
            row_q      <= '0;
            map_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            map_done_q <= retire && row_end;
            if (wr_en) begin
                wr_ptr_q <= !wr_ptr_q;
            end
            if (retire) begin
                rd_ptr_q <= !rd_ptr_q;
            end
        end
    end

    // Bank contents survive clear; a row offered alongside clear is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_q[0] <= '0;
            bank_q[1] <= '0;
        end else if (wr_en && !clear) begin
            bank_q[wr_ptr_q] <= row_in;
        end
    end

`ifdef DEBUG
    shortreal dbgBank [2][OUT_COL];
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            for (int c = 0; c < OUT_COL; c++) begin
                dbgBank[b][c] = $bitstoshortreal(bank_q[b][(OUT_COL-1-c)*DATA_WIDTH +: DATA_WIDTH]);
            end
        end
    end
`endif

endmodule

// File: tb/tb_conv_layer_output_buffer.sv
// Directed bench for conv_layer_output_buffer: streaming, backpressure,
// write/retire overlap, map wrap, clear and asynchronous reset.
module tb_conv_layer_output_buffer;

    localparam int DW   = 32;
    localparam int COLS = 6;

    logic                 clk;
    logic                 rst;
    logic                 clear;
    logic [COLS*DW-1:0]   rowIn;
    logic                 rowValid;
    logic                 rowReady;
    logic [DW-1:0]        outData;
    logic                 outValid;
    logic                 outReady;
    logic [2:0]           outCol;
    logic [2:0]           outRow;
    logic                 outEol;
    logic                 outLast;
    logic                 mapDone;

    int checks;
    int passes;
    int failures;

    logic [31:0] floatVals [6];
    logic [COLS*DW-1:0] floatRow;

    conv_layer_output_buffer dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .row_in    (rowIn),
        .row_valid (rowValid),
        .row_ready (rowReady),
        .out_data  (outData),
        .out_valid (outValid),
        .out_ready (outReady),
        .out_col   (outCol),
        .out_row   (outRow),
        .out_eol   (outEol),
        .out_last  (outLast),
        .map_done  (mapDone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Row whose column c carries base + c.
    function automatic logic [COLS*DW-1:0] makeRow(input logic [31:0] base);
        logic [COLS*DW-1:0] r;
        r = '0;
        for (int c = 0; c < COLS; c++) begin
            r[(COLS-1-c)*DW +: DW] = base + 32'(c);
        end
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) passes++;
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Present one row for a single edge.
    task automatic applyStimulus(input logic [COLS*DW-1:0] row);
        rowIn    = row;
        rowValid = 1'b1;
        stepCycle();
        rowValid = 1'b0;
    endtask

    task automatic doClear();
        clear = 1'b1;
        stepCycle();
        clear = 1'b0;
    endtask

    initial begin
        checks   = 0;
        passes   = 0;
        failures = 0;
        floatVals[0] = 32'h3F800000;
        floatVals[1] = 32'h40000000;
        floatVals[2] = 32'h40400000;
        floatVals[3] = 32'h40800000;
        floatVals[4] = 32'h40A00000;
        floatVals[5] = 32'h40C00000;
        floatRow = {32'h3F800000, 32'h40000000, 32'h40400000,
                    32'h40800000, 32'h40A00000, 32'h40C00000};

        rst      = 1'b1;
        clear    = 1'b0;
        rowIn    = '0;
        rowValid = 1'b0;
        outReady = 1'b0;
        #1;
        checkOutput("reset_row_ready", 32'(rowReady), 32'd1);
        checkOutput("reset_out_valid", 32'(outValid), 32'd0);
        checkOutput("reset_out_data",  outData, 32'd0);
        checkOutput("reset_eol_last",  {30'd0, outEol, outLast}, 32'd0);
        checkOutput("reset_map_done",  32'(mapDone), 32'd0);
        checkOutput("reset_col_row",   {26'd0, outCol, outRow}, 32'd0);
        stepCycle();
        stepCycle();
        rst = 1'b0;
        stepCycle();

        // Single row of 1.0..6.0 streamed with downstream always ready.
        $display("[TB] single row");
        outReady = 1'b1;
        applyStimulus(floatRow);
        for (int c = 0; c < COLS; c++) begin
            checkOutput($sformatf("single_valid_c%0d", c), 32'(outValid), 32'd1);
            checkOutput($sformatf("single_data_c%0d", c), outData, floatVals[c]);
            checkOutput($sformatf("single_col_c%0d", c), 32'(outCol), 32'(c));
            checkOutput($sformatf("single_eol_c%0d", c), 32'(outEol), 32'(c == 5));
            stepCycle();
        end
        checkOutput("single_empty_valid", 32'(outValid), 32'd0);
        checkOutput("single_empty_ready", 32'(rowReady), 32'd1);
        checkOutput("single_row_advanced", 32'(outRow), 32'd1);
        doClear();
        checkOutput("clear_row_zero", 32'(outRow), 32'd0);

        // Two rows buffered under backpressure; a third is refused.
        $display("[TB] backpressure");
        outReady = 1'b0;
        applyStimulus(makeRow(32'hA0000000));
        checkOutput("bp_ready_after_one", 32'(rowReady), 32'd1);
        applyStimulus(makeRow(32'hB0000000));
        rowIn    = makeRow(32'hC0000000);
        rowValid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            checkOutput($sformatf("bp_ready_low_%0d", i), 32'(rowReady), 32'd0);
            checkOutput($sformatf("bp_data_hold_%0d", i), outData, 32'hA0000000);
            checkOutput($sformatf("bp_col_hold_%0d", i), 32'(outCol), 32'd0);
            stepCycle();
        end
        rowValid = 1'b0;
        outReady = 1'b1;
        for (int i = 0; i < 12; i++) begin
            checkOutput($sformatf("bp_valid_%0d", i), 32'(outValid), 32'd1);
            checkOutput($sformatf("bp_data_%0d", i), outData,
                        ((i < 6) ? 32'hA0000000 : 32'hB0000000) + 32'(i % 6));
            stepCycle();
        end
        checkOutput("bp_drained", 32'(outValid), 32'd0);
        doClear();

        // Next row written in the same cycle the last column retires.
        $display("[TB] simultaneous write and retire");
        applyStimulus(makeRow(32'h11110000));
        for (int c = 0; c < COLS; c++) begin
            checkOutput($sformatf("sim_data_c%0d", c), outData, 32'h11110000 + 32'(c));
            if (c == 5) begin
                checkOutput("sim_ready_at_retire", 32'(rowReady), 32'd1);
                rowIn    = makeRow(32'h22220000);
                rowValid = 1'b1;
            end
            stepCycle();
        end
        rowValid = 1'b0;
        checkOutput("sim_no_bubble_valid", 32'(outValid), 32'd1);
        checkOutput("sim_no_bubble_data", outData, 32'h22220000);
        checkOutput("sim_no_bubble_col", 32'(outCol), 32'd0);
        checkOutput("sim_stays_one", 32'(rowReady), 32'd1);
        for (int c = 0; c < COLS; c++) begin
            stepCycle();
        end
        checkOutput("sim_drained", 32'(outValid), 32'd0);
        doClear();

        // Full feature map plus one row to see the wrap and map_done pulse.
        $display("[TB] map end");
        for (int r = 0; r < 7; r++) begin
            applyStimulus(makeRow(32'h30000000 + 32'(r << 8)));
            checkOutput($sformatf("map_done_low_r%0d", r), 32'(mapDone), 32'd0);
            for (int c = 0; c < COLS; c++) begin
                checkOutput($sformatf("map_row_r%0d_c%0d", r, c), 32'(outRow), 32'(r % 6));
                checkOutput($sformatf("map_last_r%0d_c%0d", r, c), 32'(outLast),
                            32'(r == 5 && c == 5));
                stepCycle();
            end
            checkOutput($sformatf("map_done_r%0d", r), 32'(mapDone), 32'(r == 5));
        end
        doClear();

        // clear in the middle of row 2 beats the row offered alongside it.
        $display("[TB] clear mid-row");
        for (int r = 0; r < 3; r++) begin
            applyStimulus(makeRow(32'h40000000 + 32'(r << 8)));
            for (int c = 0; c < ((r == 2) ? 3 : COLS); c++) begin
                stepCycle();
            end
        end
        checkOutput("clr_pre_col", 32'(outCol), 32'd3);
        checkOutput("clr_pre_row", 32'(outRow), 32'd2);
        clear    = 1'b1;
        rowIn    = makeRow(32'h5A5A0000);
        rowValid = 1'b1;
        stepCycle();
        clear    = 1'b0;
        rowValid = 1'b0;
        checkOutput("clr_valid", 32'(outValid), 32'd0);
        checkOutput("clr_ready", 32'(rowReady), 32'd1);
        checkOutput("clr_row", 32'(outRow), 32'd0);
        checkOutput("clr_col", 32'(outCol), 32'd0);
        checkOutput("clr_map_done", 32'(mapDone), 32'd0);
        stepCycle();
        checkOutput("clr_row_dropped", 32'(outValid), 32'd0);

        // Asynchronous reset between edges while a row is streaming.
        $display("[TB] async reset");
        applyStimulus(makeRow(32'h60000000));
        stepCycle();
        stepCycle();
        checkOutput("arst_pre_col", 32'(outCol), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst_valid", 32'(outValid), 32'd0);
        checkOutput("arst_col", 32'(outCol), 32'd0);
        checkOutput("arst_data", outData, 32'd0);
        checkOutput("arst_ready", 32'(rowReady), 32'd1);
        stepCycle();
        rst = 1'b0;
        stepCycle();
        checkOutput("arst_idle", 32'(outValid), 32'd0);
        applyStimulus(floatRow);
        checkOutput("arst_first_data", outData, 32'h3F800000);
        checkOutput("arst_first_col", 32'(outCol), 32'd0);
        checkOutput("arst_first_row", 32'(outRow), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
